// File: rtl/muldiv_unit_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// The master is the requester and the slave is muldiv_unit.
interface muldiv_unit_if #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned OPCODE_LENGTH = 3
);
    logic                     in_valid;
    logic                     in_ready;
    logic [OPCODE_LENGTH-1:0] Operation;
    logic [DATA_WIDTH-1:0]    SrcA;
    logic [DATA_WIDTH-1:0]    SrcB;
    logic                     flush;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_WIDTH-1:0]    Result;

    modport master (
        output in_valid, Operation, SrcA, SrcB, flush, out_ready,
        input  in_ready, out_valid, Result
    );

    modport slave (
        input  in_valid, Operation, SrcA, SrcB, flush, out_ready,
        output in_ready, out_valid, Result
    );
endinterface

// File: rtl/muldiv_unit.sv
// RV32M-style multiply/divide unit: one radix-2 shift-add / restoring-divide step per cycle,
// operating on operand magnitudes with sign fix-up applied when the result is registered.
module muldiv_unit #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned OPCODE_LENGTH = 3
) (
    input logic          clk,
    input logic          rst_n,
    muldiv_unit_if.slave bus
);
    localparam int unsigned W        = DATA_WIDTH;
    localparam int unsigned CntWidth = $clog2(DATA_WIDTH + 1);

    localparam logic [OPCODE_LENGTH-1:0] OpMul    = OPCODE_LENGTH'(0);
    localparam logic [OPCODE_LENGTH-1:0] OpMulh   = OPCODE_LENGTH'(1);
    localparam logic [OPCODE_LENGTH-1:0] OpMulhsu = OPCODE_LENGTH'(2);
    localparam logic [OPCODE_LENGTH-1:0] OpMulhu  = OPCODE_LENGTH'(3);
    localparam logic [OPCODE_LENGTH-1:0] OpDiv    = OPCODE_LENGTH'(4);
    localparam logic [OPCODE_LENGTH-1:0] OpDivu   = OPCODE_LENGTH'(5);
    localparam logic [OPCODE_LENGTH-1:0] OpRem    = OPCODE_LENGTH'(6);
    localparam logic [OPCODE_LENGTH-1:0] OpRemu   = OPCODE_LENGTH'(7);

    localparam logic [W-1:0] SignedMin = {1'b1, {(W - 1) {1'b0}}};

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e                   state_q, state_d;
    logic [CntWidth-1:0]      cnt_q, cnt_d;
    logic [W-1:0]             acc_q, acc_d;
    logic [W-1:0]             lo_q, lo_d;
    logic [W-1:0]             opb_q, opb_d;
    logic [W-1:0]             result_q, result_d;
    logic [OPCODE_LENGTH-1:0] op_q, op_d;
    logic                     a_neg_q, a_neg_d;
    logic                     b_neg_q, b_neg_d;

    // Incoming request decode
    logic         in_is_div, in_div_zero, in_ovf, fast_path;
    logic         in_signed_a, in_signed_b, in_a_neg, in_b_neg;
    logic [W-1:0] mag_a, mag_b, fast_result;

    always_comb begin
        in_is_div   = bus.Operation[2];
        in_div_zero = in_is_div && (bus.SrcB == '0);
        in_ovf      = in_is_div && !bus.Operation[0] && (bus.SrcA == SignedMin) &&
                      (bus.SrcB == '1);
        fast_path   = in_div_zero || in_ovf;
        in_signed_a = (bus.Operation == OpMulh) || (bus.Operation == OpMulhsu) ||
                      (bus.Operation == OpDiv)  || (bus.Operation == OpRem);
        in_signed_b = (bus.Operation == OpMulh) || (bus.Operation == OpDiv) ||
                      (bus.Operation == OpRem);
        in_a_neg    = in_signed_a && bus.SrcA[W-1];
        in_b_neg    = in_signed_b && bus.SrcB[W-1];
        mag_a       = in_a_neg ? -bus.SrcA : bus.SrcA;
        mag_b       = in_b_neg ? -bus.SrcB : bus.SrcB;
        if (in_div_zero) begin
            fast_result = bus.Operation[1] ? bus.SrcA : '1;
        end else begin
            fast_result = bus.Operation[1] ? '0 : SignedMin;
        end
    end

    // One iteration step; acc holds product-high / remainder, lo holds multiplier / quotient
    logic [W:0]     mul_sum, rem_sh, trial;
    logic [W-1:0]   iter_acc, iter_lo;
    logic [2*W-1:0] prod, prod_s;
    logic [W-1:0]   quo_s, rem_s, final_result;

    always_comb begin
        mul_sum = {1'b0, acc_q} + ({1'b0, opb_q} & {(W + 1) {lo_q[0]}});
        rem_sh  = {acc_q, lo_q[W-1]};
        trial   = rem_sh - {1'b0, opb_q};
        if (op_q[2]) begin
            if (!trial[W]) begin
                iter_acc = trial[W-1:0];
                iter_lo  = {lo_q[W-2:0], 1'b1};
            end else begin
                iter_acc = rem_sh[W-1:0];
                iter_lo  = {lo_q[W-2:0], 1'b0};
            end
        end else begin
            iter_acc = mul_sum[W:1];
            iter_lo  = {mul_sum[0], lo_q[W-1:1]};
        end

        prod   = {acc_q, lo_q};
        prod_s = (a_neg_q ^ b_neg_q) ? -prod : prod;
        quo_s  = (a_neg_q ^ b_neg_q) ? -lo_q : lo_q;
        rem_s  = a_neg_q ? -acc_q : acc_q;
        unique case (op_q)
            OpMul:                      final_result = prod_s[W-1:0];
            OpMulh, OpMulhsu, OpMulhu:  final_result = prod_s[2*W-1:W];
            OpDiv, OpDivu:              final_result = quo_s;
            OpRem, OpRemu:              final_result = rem_s;
            default:                    final_result = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        opb_d    = opb_q;
        op_d     = op_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        result_d = result_q;
        unique case (state_q)
            StIdle: begin
                // flush in IDLE blocks acceptance even though in_ready stays high
                if (bus.in_valid && !bus.flush) begin
                    op_d = bus.Operation;
                    if (fast_path) begin
                        state_d  = StDone;
                        result_d = fast_result;
                    end else begin
                        state_d = StBusy;
                        cnt_d   = '0;
                        acc_d   = '0;
                        lo_d    = mag_a;
                        opb_d   = mag_b;
                        a_neg_d = in_a_neg;
                        b_neg_d = in_b_neg;
                    end
                end
            end
            StBusy: begin
                if (bus.flush) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == CntWidth'(W)) begin
                    // W steps done; this extra cycle applies the sign fix-up
                    state_d  = StDone;
                    cnt_d    = '0;
                    result_d = final_result;
                end else begin
                    cnt_d = cnt_q + CntWidth'(1);
                    acc_d = iter_acc;
                    lo_d  = iter_lo;
                end
            end
            StDone: begin
                if (bus.flush || bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            opb_q    <= '0;
            result_q <= '0;
            op_q     <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            op_q     <= op_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.Result    = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit (DATA_WIDTH=32) against an arithmetic model.
module tb_muldiv_unit;
    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
    localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;
    localparam logic [31:0] SMIN = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    muldiv_unit_if #(.DATA_WIDTH(32), .OPCODE_LENGTH(3)) bus ();

    muldiv_unit #(.DATA_WIDTH(32), .OPCODE_LENGTH(3)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] p;
        int          sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            MUL:    begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            MULH:   begin p = longint'(sa) * longint'(sb); return p[63:32]; end
            MULHSU: begin p = longint'(sa) * longint'({32'b0, b}); return p[63:32]; end
            MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            DIV:    begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == SMIN && b == 32'hFFFF_FFFF) return SMIN;
                return 32'(sa / sb);
            end
            REM:    begin
                if (b == 0) return a;
                if (a == SMIN && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (op >= DIV && b == 0) return 1;
        if ((op == DIV || op == REM) && a == SMIN && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Presents a request, lets the next edge accept it, then scrambles the inputs.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.Operation = op;
        bus.SrcA      = a;
        bus.SrcB      = b;
        bus.in_valid  = 1'b1;
        #1;
        check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.Operation = 3'($urandom);
        bus.SrcA      = $urandom;
        bus.SrcB      = $urandom;
    endtask

    // Counts edges from acceptance until out_valid, bounded at 200 edges.
    task automatic wait_result(input string tag, input logic [31:0] exp_val, input int exp_lat);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.out_valid && n < 200);
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check({tag, "_result"}, bus.Result, exp_val);
    endtask

    task automatic deliver(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, "_released"}, 32'(bus.out_valid), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        issue(op, a, b);
        wait_result(tag, ref_result(op, a, b), ref_latency(op, a, b));
        deliver(tag);
    endtask

    initial begin
        logic [31:0] held;
        logic        seen;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        bus.in_valid  = 1'b0;
        bus.Operation = '0;
        bus.SrcA      = '0;
        bus.SrcB      = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;

        #23;
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_result", bus.Result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mul_7xm3", MUL, 32'd7, 32'hFFFF_FFFD);
        run_op("mulh_min", MULH, SMIN, SMIN);
        run_op("mulhu_ones", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulhsu_ones", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2);
        run_op("rem_m7_2", REM, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_100_7", DIVU, 32'd100, 32'd7);
        run_op("remu_100_7", REMU, 32'd100, 32'd7);
        run_op("div_by0", DIV, 32'h1234, 32'd0);
        run_op("remu_by0", REMU, 32'h1234, 32'd0);
        run_op("div_ovf", DIV, SMIN, 32'hFFFF_FFFF);
        run_op("rem_ovf", REM, SMIN, 32'hFFFF_FFFF);

        // Stall in DONE with a new request waiting on the bus
        issue(DIVU, 32'd100, 32'd7);
        wait_result("stall_first", 32'd14, 33);
        held = bus.Result;
        bus.Operation = REMU;
        bus.SrcA      = 32'd100;
        bus.SrcB      = 32'd7;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall_out_valid", 32'(bus.out_valid), 32'd1);
            check("stall_result", bus.Result, held);
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("handshake_out_valid", 32'(bus.out_valid), 32'd0);
        check("no_bypass_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("accept_after_idle", 32'(bus.in_ready), 32'd0);
        wait_result("stall_second", 32'd2, 33);
        deliver("stall_second");

        // flush in IDLE suppresses acceptance
        bus.Operation = DIVU;
        bus.SrcA      = 32'd50;
        bus.SrcB      = 32'd5;
        bus.in_valid  = 1'b1;
        bus.flush     = 1'b1;
        #1;
        check("flush_idle_ready_comb", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        check("flush_idle_no_accept", 32'(bus.in_ready), 32'd1);

        // flush beats out_ready in DONE
        issue(DIV, 32'h55, 32'd0);
        wait_result("flush_done", 32'hFFFF_FFFF, 1);
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        check("flush_done_out_valid", 32'(bus.out_valid), 32'd0);
        check("flush_done_in_ready", 32'(bus.in_ready), 32'd1);

        // flush at BUSY cycle 10
        issue(MUL, 32'h1234_5678, 32'h9ABC_DEF0);
        seen = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
            seen |= bus.out_valid;
        end
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("flush_busy_in_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            seen |= bus.out_valid;
        end
        check("flush_busy_no_out_valid", 32'(seen), 32'd0);

        // Reset mid-BUSY, then a request on the first edge after release
        issue(MULHU, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            seen |= bus.out_valid;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("async_reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("async_reset_result", bus.Result, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            seen |= bus.out_valid;
        end
        @(negedge clk);
        rst_n = 1'b1;
        issue(DIVU, 32'd9, 32'd3);
        wait_result("post_reset_divu", 32'd3, 33);
        check("reset_op_no_out_valid", 32'(seen), 32'd0);
        deliver("post_reset_divu");

        // Randomized operations with corner-biased operands
        for (int k = 0; k < 150; k++) begin
            rop = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0:       ra = 32'd0;
                1:       ra = 32'hFFFF_FFFF;
                2:       ra = SMIN;
                3:       ra = $urandom_range(0, 100);
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = SMIN;
                3:       rb = $urandom_range(1, 100);
                default: rb = $urandom;
            endcase
            issue(rop, ra, rb);
            wait_result($sformatf("rand%0d_op%0d_%08h_%08h", k, rop, ra, rb),
                        ref_result(rop, ra, rb), ref_latency(rop, ra, rb));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            check($sformatf("rand%0d_hold", k), bus.Result, ref_result(rop, ra, rb));
            deliver($sformatf("rand%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/result width; SHALL be even and >= 4.
REQ-002 Parameter OPCODE_LENGTH, default 3, Operation width; SHALL be fixed at 3 (RV M-extension funct3).
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 in_valid  in  1  request present.
REQ-006 in_ready  out  1  unit can accept a request.
REQ-007 Operation  in  OPCODE_LENGTH  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 SrcA  in  DATA_WIDTH  rs1 operand / dividend.
REQ-009 SrcB  in  DATA_WIDTH  rs2 operand / divisor.
REQ-010 flush  in  1  abort the in-flight operation.
REQ-011 out_valid  out  1  Result valid.
REQ-012 out_ready  in  1  consumer takes Result.
REQ-013 Result  out  DATA_WIDTH  operation result.

Function
REQ-014 States SHALL be IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 A request SHALL be accepted on a rising edge where in_valid && in_ready; Operation, SrcA, SrcB SHALL be captured at that edge and later input changes SHALL be ignored.
REQ-016 Normal ops: IDLE->BUSY on acceptance; BUSY SHALL perform exactly one radix-2 iteration per cycle for DATA_WIDTH cycles; out_valid SHALL rise DATA_WIDTH+1 edges after the accepting edge.
REQ-017 Fast path: DIV/DIVU/REM/REMU with SrcB==0, and DIV/REM with SrcA==signed-min and SrcB==all-ones, SHALL go IDLE->DONE directly; out_valid SHALL rise 1 edge after acceptance.
REQ-018 DONE->IDLE on an edge with out_ready=1; Result and out_valid SHALL hold stable while out_ready=0.
REQ-019 Unit SHALL NOT accept a new request in the cycle it leaves DONE (no back-to-back bypass); earliest acceptance is the following edge.
REQ-020 MUL SHALL return low DATA_WIDTH bits of the product; MULH/MULHSU/MULHU SHALL return high DATA_WIDTH bits of the 2*DATA_WIDTH product with operands signed/signed, signed/unsigned, unsigned/unsigned.
REQ-021 DIV/REM SHALL truncate toward zero; remainder sign SHALL equal dividend sign; DIVU/REMU unsigned.
REQ-022 Divide by zero: DIV/DIVU SHALL return all-ones, REM/REMU SHALL return SrcA.
REQ-023 Signed overflow (min / -1): DIV SHALL return signed-min, REM SHALL return 0.
REQ-024 flush=1 in BUSY or DONE SHALL force IDLE at the next edge, discard the result, and deassert out_valid; flush in IDLE SHALL suppress acceptance that edge (in_ready is still 1 combinationally, in_valid ignored).
REQ-025 flush and out_ready both high in DONE: flush wins, result treated as not delivered.
REQ-026 Internal iteration counter SHALL be ceil(log2(DATA_WIDTH+1)) bits and SHALL NOT wrap within an operation.

Reset
REQ-027 rst_n=0 SHALL immediately (asynchronously) force IDLE, counter 0, Result 0, out_valid 0; in_ready SHALL read 1 while rst_n=0.
REQ-028 Reset asserted mid-BUSY SHALL abandon the operation; after rst_n deasserts, the first accepted request SHALL produce a correct result unaffected by prior state.
REQ-029 Deassertion of rst_n SHALL be treated as synchronised externally; unit SHALL accept a request on the first edge after deassertion.

Verification (DATA_WIDTH=32)
REQ-030 MUL 7 x 0xFFFFFFFD -> Result 0xFFFFFFEB, out_valid exactly 33 edges after accept.
REQ-031 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-032 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14, REMU -> 2.
REQ-033 DIV 0x1234 / 0 -> 0xFFFFFFFF, REMU 0x1234 / 0 -> 0x1234, DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0; each out_valid 1 edge after accept.
REQ-034 out_ready held 0 for 5 cycles in DONE -> Result and out_valid stable; in_valid held 1 meanwhile -> no acceptance until 1 edge after the handshake.
REQ-035 flush at BUSY cycle 10, then rst_n pulsed low during a second op's BUSY -> no out_valid for either; next DIVU 9/3 -> 3 with normal latency.
